// File: rtl/bias_add_stage.sv
`default_nettype none
// ============================================================================
// Module   : bias_add_stage
// Purpose  : Two-stage valid/ready pipeline that adds a per-lane bias to
//            adder-tree partial sums and saturates each lane to 18 bits.
//            Define BIAS_RELU_EN to clamp negative lane results to zero.
// Revision : 1.0 - initial release
// ============================================================================
module bias_add_stage #(
    parameter int N_adder_tree = 16,
    parameter int BEATS        = 196
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_adder_tree*18-1:0] in_data,
    input  logic [N_adder_tree*18-1:0] bias,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_adder_tree*18-1:0] out_data,
    output logic                       out_last,
    output logic                       sat_flag
);

    localparam int c_LANE_W = 18;
    localparam int c_SUM_W  = 19;
    localparam int c_VEC_W  = N_adder_tree * c_LANE_W;
    localparam int c_SUMV_W = N_adder_tree * c_SUM_W;
    localparam int c_CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(BEATS - 1);

    logic                    w_stall;
    logic                    w_in_xfer;
    logic [c_SUMV_W-1:0]     w_sum;
    logic [c_VEC_W-1:0]      w_sat_data;
    logic [N_adder_tree-1:0] w_lane_ovf;

    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_s1_valid;
    logic [c_SUMV_W-1:0]     r_s1_sum;
    logic [c_CNT_W-1:0]      r_s1_idx;
    logic                    r_s2_valid;
    logic [c_VEC_W-1:0]      r_s2_data;
    logic [c_CNT_W-1:0]      r_s2_idx;
    logic                    r_s2_ovf;
    logic                    r_sat_flag;

    // The whole pipe freezes while the output beat is refused downstream.
    assign w_stall   = r_s2_valid & ~out_ready;
    assign in_ready  = rst | ~w_stall;
    assign w_in_xfer = in_valid & in_ready;

    generate
        for (genvar k = 0; k < N_adder_tree; k++) begin : g_lane
            logic [c_LANE_W-1:0] w_a;
            logic [c_LANE_W-1:0] w_b;
            logic [c_SUM_W-1:0]  w_s1;
            logic                w_ovf;
            logic [c_LANE_W-1:0] w_clip;

            assign w_a = in_data[c_LANE_W*k +: c_LANE_W];
            assign w_b = bias[c_LANE_W*k +: c_LANE_W];
            assign w_sum[c_SUM_W*k +: c_SUM_W] = {w_a[c_LANE_W-1], w_a} + {w_b[c_LANE_W-1], w_b};

            // A 19-bit sum fits 18 bits only when its top two bits agree.
            assign w_s1   = r_s1_sum[c_SUM_W*k +: c_SUM_W];
            assign w_ovf  = w_s1[c_SUM_W-1] ^ w_s1[c_SUM_W-2];
            assign w_clip = w_ovf ? (w_s1[c_SUM_W-1] ? 18'h20000 : 18'h1FFFF)
                                  : w_s1[c_LANE_W-1:0];
            assign w_lane_ovf[k] = w_ovf;
`ifdef BIAS_RELU_EN
            assign w_sat_data[c_LANE_W*k +: c_LANE_W] = w_clip[c_LANE_W-1] ? '0 : w_clip;
`else
            assign w_sat_data[c_LANE_W*k +: c_LANE_W] = w_clip;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_idx   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_idx   <= '0;
            r_s2_ovf   <= 1'b0;
            r_sat_flag <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_cnt <= (r_cnt == c_LAST_IDX) ? '0 : r_cnt + 1'b1;
            end
            if (!w_stall) begin
                r_s1_valid <= w_in_xfer;
                if (w_in_xfer) begin
                    r_s1_sum <= w_sum;
                    r_s1_idx <= r_cnt;
                end
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_data <= w_sat_data;
                    r_s2_idx  <= r_s1_idx;
                    r_s2_ovf  <= |w_lane_ovf;
                end
            end
            // Overflow only; the ReLU clamp never raises the flag.
            if (r_s2_valid && r_s2_ovf) begin
                r_sat_flag <= 1'b1;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_last  = r_s2_valid & (r_s2_idx == c_LAST_IDX);
    assign sat_flag  = r_sat_flag;

endmodule
`default_nettype wire
